// File: rtl/board_lock_clear.sv
// board_lock_clear
//   Owns the 10x12 settled-cell playfield. When the mover reports a landed
//   piece it locks the four cells in, collapses any full rows (one row
//   examined per cycle), counts cleared lines, then requests the next piece
//   or enters game-over.
//
// Ports
//   Clk, Reset     clock, asynchronous active-high reset
//   Ack            restart request, honoured only in OVER
//   bottom_flag    mover has stopped the piece (level)
//   top_flag       landed piece touches row 11 (level)
//   x1..x4, y1..y4 piece cell coordinates (column 0..9, row 0..11)
//   arr0..arr11    registered board rows, bit i = column i
//   gen_flag       one-cycle spawn request
//   game_over      high while in OVER
//   lines          saturating count of cleared rows
//   state          FSM state code
//
// state | meaning
// INI   | board and line count cleared
// GEN   | gen_flag pulse, spawn counter loaded
// SPAWN | mover still settling; bottom_flag ignored
// PLAY  | waiting for the piece to land
// LOCK  | captured cells written into the board
// CLEAR | scan rows upward, collapsing full ones
// OVER  | board frozen until Ack
module board_lock_clear #(
    parameter int SCORE_W    = 16,
    parameter int SPAWN_WAIT = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Ack,
    input  logic               bottom_flag,
    input  logic               top_flag,
    input  logic [3:0]         x1,
    input  logic [3:0]         x2,
    input  logic [3:0]         x3,
    input  logic [3:0]         x4,
    input  logic [3:0]         y1,
    input  logic [3:0]         y2,
    input  logic [3:0]         y3,
    input  logic [3:0]         y4,
    output logic [9:0]         arr0,
    output logic [9:0]         arr1,
    output logic [9:0]         arr2,
    output logic [9:0]         arr3,
    output logic [9:0]         arr4,
    output logic [9:0]         arr5,
    output logic [9:0]         arr6,
    output logic [9:0]         arr7,
    output logic [9:0]         arr8,
    output logic [9:0]         arr9,
    output logic [9:0]         arr10,
    output logic [9:0]         arr11,
    output logic               gen_flag,
    output logic               game_over,
    output logic [SCORE_W-1:0] lines,
    output logic [2:0]         state
);

    localparam logic [2:0] INI   = 3'd0;
    localparam logic [2:0] GEN   = 3'd1;
    localparam logic [2:0] SPAWN = 3'd2;
    localparam logic [2:0] PLAY  = 3'd3;
    localparam logic [2:0] LOCK  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;
    localparam logic [2:0] OVER  = 3'd6;

    localparam int CNT_W = (SPAWN_WAIT < 2) ? 1 : $clog2(SPAWN_WAIT + 1);

    logic [9:0]         board     [12];
    logic [9:0]         board_nxt [12];
    logic [2:0]         state_nxt;
    logic [3:0]         row_ptr, row_ptr_nxt;
    logic [CNT_W-1:0]   spawn_cnt, spawn_cnt_nxt;
    logic [SCORE_W-1:0] lines_nxt;
    logic [3:0]         hold_x [4];
    logic [3:0]         hold_y [4];
    logic               hold_top;
    logic               row_full;

    assign row_full = (board[row_ptr] == 10'h3FF);

    always_comb begin
        state_nxt     = state;
        row_ptr_nxt   = row_ptr;
        spawn_cnt_nxt = spawn_cnt;
        lines_nxt     = lines;
        for (int r = 0; r < 12; r++) board_nxt[r] = board[r];

        case (state)
            INI: begin
                for (int r = 0; r < 12; r++) board_nxt[r] = '0;
                lines_nxt = '0;
                state_nxt = GEN;
            end
            GEN: begin
                spawn_cnt_nxt = CNT_W'(SPAWN_WAIT);
                state_nxt     = SPAWN;
            end
            SPAWN: begin
                // Leave after SPAWN_WAIT cycles in this state.
                spawn_cnt_nxt = spawn_cnt - 1'b1;
                if (spawn_cnt <= CNT_W'(1)) state_nxt = PLAY;
            end
            PLAY: begin
                if (bottom_flag) state_nxt = LOCK;
            end
            LOCK: begin
                // Out-of-range cells are dropped rather than wrapped.
                for (int k = 0; k < 4; k++) begin
                    if (hold_x[k] <= 4'd9 && hold_y[k] <= 4'd11)
                        board_nxt[hold_y[k]][hold_x[k]] = 1'b1;
                end
                row_ptr_nxt = '0;
                state_nxt   = hold_top ? OVER : CLEAR;
            end
            CLEAR: begin
                if (row_full) begin
                    // Pointer stays put so the row shifted in gets rechecked.
                    for (int r = 0; r < 11; r++) begin
                        if (4'(r) >= row_ptr) board_nxt[r] = board[r+1];
                    end
                    board_nxt[11] = '0;
                    if (lines != '1) lines_nxt = lines + 1'b1;
                end else if (row_ptr == 4'd11) begin
                    state_nxt = GEN;
                end else begin
                    row_ptr_nxt = row_ptr + 4'd1;
                end
            end
            OVER: begin
                if (Ack) state_nxt = INI;
            end
            default: state_nxt = INI;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= INI;
            row_ptr   <= '0;
            spawn_cnt <= '0;
            lines     <= '0;
            hold_top  <= 1'b0;
            for (int r = 0; r < 12; r++) board[r] <= '0;
            for (int k = 0; k < 4; k++) begin
                hold_x[k] <= '0;
                hold_y[k] <= '0;
            end
        end else begin
            state     <= state_nxt;
            row_ptr   <= row_ptr_nxt;
            spawn_cnt <= spawn_cnt_nxt;
            lines     <= lines_nxt;
            for (int r = 0; r < 12; r++) board[r] <= board_nxt[r];
            if (state == PLAY && bottom_flag) begin
                hold_x[0] <= x1;
                hold_x[1] <= x2;
                hold_x[2] <= x3;
                hold_x[3] <= x4;
                hold_y[0] <= y1;
                hold_y[1] <= y2;
                hold_y[2] <= y3;
                hold_y[3] <= y4;
                hold_top  <= top_flag;
            end
        end
    end

    assign gen_flag  = (state == GEN);
    assign game_over = (state == OVER);

    assign arr0  = board[0];
    assign arr1  = board[1];
    assign arr2  = board[2];
    assign arr3  = board[3];
    assign arr4  = board[4];
    assign arr5  = board[5];
    assign arr6  = board[6];
    assign arr7  = board[7];
    assign arr8  = board[8];
    assign arr9  = board[9];
    assign arr10 = board[10];
    assign arr11 = board[11];

endmodule

// File: tb/tb_board_lock_clear.sv
// tb_board_lock_clear
//   Directed-vector bench for board_lock_clear: reset, plain landing,
//   single and quadruple clears, dropped out-of-range cells, top-out,
//   restart, and bottom_flag held through GEN/SPAWN.
module tb_board_lock_clear;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Ack = 1'b0;
    logic        bottom_flag = 1'b0;
    logic        top_flag = 1'b0;
    logic [3:0]  x1 = 4'd13, x2 = 4'd13, x3 = 4'd13, x4 = 4'd13;
    logic [3:0]  y1 = 4'd13, y2 = 4'd13, y3 = 4'd13, y4 = 4'd13;
    logic [9:0]  arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
    logic        gen_flag, game_over;
    logic [15:0] lines;
    logic [2:0]  state;

    logic [9:0]  rows [12];
    int          total = 0;
    int          bad = 0;
    int          clr_cnt;
    logic        got_gen;
    logic        prev_gen;
    int          locks_early;
    logic        seen_play;

    always #5 Clk = ~Clk;

    board_lock_clear #(.SCORE_W(16), .SPAWN_WAIT(2)) dut (
        .Clk(Clk), .Reset(Reset), .Ack(Ack),
        .bottom_flag(bottom_flag), .top_flag(top_flag),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3),
        .arr4(arr4), .arr5(arr5), .arr6(arr6), .arr7(arr7),
        .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11),
        .gen_flag(gen_flag), .game_over(game_over),
        .lines(lines), .state(state)
    );

    always_comb begin
        rows[0] = arr0;  rows[1] = arr1;  rows[2]  = arr2;  rows[3]  = arr3;
        rows[4] = arr4;  rows[5] = arr5;  rows[6]  = arr6;  rows[7]  = arr7;
        rows[8] = arr8;  rows[9] = arr9;  rows[10] = arr10; rows[11] = arr11;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Waits for PLAY, presents one piece (x packed with cell 1 in [3:0]),
    // then runs until the next gen_flag or game_over, counting CLEAR cycles.
    task automatic land(input logic [15:0] xs, input logic [15:0] ys, input logic top,
                        output int clears, output logic gen_seen);
        int n;
        clears   = 0;
        gen_seen = 1'b0;
        n = 0;
        while (state !== 3'd3 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_play", {31'd0, state === 3'd3}, 32'd1);
        {x4, x3, x2, x1} = xs;
        {y4, y3, y2, y1} = ys;
        top_flag    = top;
        bottom_flag = 1'b1;
        @(negedge Clk);
        bottom_flag = 1'b0;
        top_flag    = 1'b0;
        {x4, x3, x2, x1} = 16'hDDDD;
        {y4, y3, y2, y1} = 16'hDDDD;
        n = 0;
        while (n < 100) begin
            @(negedge Clk);
            n++;
            if (state === 3'd5) clears++;
            if (gen_flag === 1'b1) begin
                gen_seen = 1'b1;
                break;
            end
            if (game_over === 1'b1) break;
        end
        chk("land_done", {31'd0, (gen_flag === 1'b1) || (game_over === 1'b1)}, 32'd1);
    endtask

    initial begin
        // 1: reset, INI then a single GEN pulse
        repeat (2) @(negedge Clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_gen", {31'd0, gen_flag}, 32'd0);
        chk("rst_lines", {16'd0, lines}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("ini_state", {29'd0, state}, 32'd0);
        @(negedge Clk);
        chk("gen_pulse", {31'd0, gen_flag}, 32'd1);
        chk("gen_state", {29'd0, state}, 32'd1);
        @(negedge Clk);
        chk("gen_once", {31'd0, gen_flag}, 32'd0);
        for (int r = 0; r < 12; r++) chk($sformatf("ini_row%0d", r), {22'd0, rows[r]}, 32'd0);

        // Ack outside OVER does nothing
        repeat (3) @(negedge Clk);
        chk("play_reached", {29'd0, state}, 32'd3);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_ignored", {29'd0, state}, 32'd3);

        // 2: square at columns 5,6 rows 0,1
        land(16'h6655, 16'h1010, 1'b0, clr_cnt, got_gen);
        chk("sq_row0", {22'd0, arr0}, 32'h060);
        chk("sq_row1", {22'd0, arr1}, 32'h060);
        chk("sq_clears", clr_cnt, 32'd12);
        chk("sq_gen", {31'd0, got_gen}, 32'd1);
        chk("sq_lines", {16'd0, lines}, 32'd0);

        // 3: single line clear with shift-down
        do_reset();
        land(16'h7654, 16'h0000, 1'b0, clr_cnt, got_gen);
        land(16'hD098, 16'hD100, 1'b0, clr_cnt, got_gen);
        chk("pre_row0", {22'd0, arr0}, 32'h3F0);
        chk("pre_row1", {22'd0, arr1}, 32'h001);
        land(16'h3210, 16'h0000, 1'b0, clr_cnt, got_gen);
        chk("one_row0", {22'd0, arr0}, 32'h001);
        chk("one_row1", {22'd0, arr1}, 32'h000);
        chk("one_lines", {16'd0, lines}, 32'd1);
        chk("one_clears", clr_cnt, 32'd13);

        // 4: four stacked rows, plus dropped x=10 / y=12 cells
        do_reset();
        for (int r = 0; r < 4; r++) begin
            land(16'h4321, {4{4'(r)}}, 1'b0, clr_cnt, got_gen);
            land(16'h8765, {4{4'(r)}}, 1'b0, clr_cnt, got_gen);
            land(16'hD3A9, {4'hD, 4'd12, 4'(r), 4'(r)}, 1'b0, clr_cnt, got_gen);
        end
        for (int r = 0; r < 4; r++) chk($sformatf("fill_row%0d", r), {22'd0, rows[r]}, 32'h3FE);
        for (int r = 4; r < 12; r++) chk($sformatf("fill_empty%0d", r), {22'd0, rows[r]}, 32'h000);
        land(16'h0000, 16'h3210, 1'b0, clr_cnt, got_gen);
        chk("four_clears", clr_cnt, 32'd16);
        chk("four_lines", {16'd0, lines}, 32'd4);
        chk("four_gen", {31'd0, got_gen}, 32'd1);
        for (int r = 0; r < 12; r++) chk($sformatf("four_row%0d", r), {22'd0, rows[r]}, 32'h000);

        // 5: top-out
        land(16'hDDD2, 16'hDDDB, 1'b1, clr_cnt, got_gen);
        chk("over_flag", {31'd0, game_over}, 32'd1);
        chk("over_state", {29'd0, state}, 32'd6);
        chk("over_row11", {22'd0, arr11}, 32'h004);
        chk("over_lines", {16'd0, lines}, 32'd4);
        chk("over_nogen", {31'd0, got_gen}, 32'd0);
        // 6 setup: bottom_flag held high from OVER onward with mover reset coords
        bottom_flag = 1'b1;
        prev_gen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            prev_gen = prev_gen | gen_flag;
        end
        chk("over_held_gen", {31'd0, prev_gen}, 32'd0);
        chk("over_held_state", {29'd0, state}, 32'd6);
        chk("over_frozen", {22'd0, arr11}, 32'h004);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("ack_ini", {29'd0, state}, 32'd0);
        @(negedge Clk);
        chk("restart_gen", {31'd0, gen_flag}, 32'd1);
        chk("restart_lines", {16'd0, lines}, 32'd0);
        chk("restart_row11", {22'd0, arr11}, 32'h000);
        locks_early = 0;
        seen_play   = 1'b0;
        prev_gen    = 1'b1;
        for (int i = 0; i < 20 && !seen_play; i++) begin
            @(negedge Clk);
            if (gen_flag === 1'b1 && prev_gen === 1'b1) chk("gen_double", 32'd1, 32'd0);
            prev_gen = gen_flag;
            if (state === 3'd4) locks_early++;
            if (state === 3'd3) seen_play = 1'b1;
        end
        chk("held_reach_play", {31'd0, seen_play}, 32'd1);
        chk("held_no_lock", locks_early, 32'd0);
        @(negedge Clk);
        chk("held_lock", {29'd0, state}, 32'd4);
        bottom_flag = 1'b0;
        got_gen = 1'b0;
        for (int i = 0; i < 40 && !got_gen; i++) begin
            @(negedge Clk);
            got_gen = gen_flag;
        end
        chk("held_gen", {31'd0, got_gen}, 32'd1);
        for (int r = 0; r < 12; r++) chk($sformatf("held_row%0d", r), {22'd0, rows[r]}, 32'h000);
        chk("held_lines", {16'd0, lines}, 32'd0);

        // Reset in the middle of a clear discards everything
        land(16'h4321, 16'h0000, 1'b0, clr_cnt, got_gen);
        land(16'h8765, 16'h0000, 1'b0, clr_cnt, got_gen);
        for (int i = 0; i < 50 && state !== 3'd3; i++) @(negedge Clk);
        {x4, x3, x2, x1} = 16'hDD09;
        {y4, y3, y2, y1} = 16'hDD00;
        bottom_flag = 1'b1;
        @(negedge Clk);
        bottom_flag = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_row0", {22'd0, arr0}, 32'h000);
        chk("midrst_lines", {16'd0, lines}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
